// File: rtl/layer_dp_buffer_if.sv
// Two-port request/response bundle for the layer buffer.
// Latency: none, wires only. Backpressure: none, reads always answer one cycle later.
// Ports: port A (CSA/WEAN/A/DIA -> DOA/DOA_vld) and port B (CSB/WEBN/B/DIB -> DOB/DOB_vld).
interface layer_dp_buffer_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8
);
  logic              CSA;
  logic              WEAN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DIA;
  logic [DATA_W-1:0] DOA;
  logic              DOA_vld;
  logic              CSB;
  logic              WEBN;
  logic [ADDR_W-1:0] B;
  logic [DATA_W-1:0] DIB;
  logic [DATA_W-1:0] DOB;
  logic              DOB_vld;

  // Requester side (layer engine / fetch unit).
  modport master (
    output CSA, WEAN, A, DIA, CSB, WEBN, B, DIB,
    input  DOA, DOA_vld, DOB, DOB_vld
  );

  // Buffer side.
  modport slave (
    input  CSA, WEAN, A, DIA, CSB, WEBN, B, DIB,
    output DOA, DOA_vld, DOB, DOB_vld
  );
endinterface

// File: rtl/layer_dp_buffer.sv
// True-dual-port CNN layer buffer with write-first forwarding, zero-fill sequencer, collision/range flags.
// Latency: reads return one cycle after request; writes land at the request edge; zero-fill takes DEPTH cycles.
// Backpressure: none; during zero-fill (clr_busy=1) all port requests are silently dropped.
// Ports: CK/rst (sync, active high), bus (slave modport of layer_dp_buffer_if), clr_start/clr_busy,
//        col_flag/col_cnt (write/write same-address collisions), oor_flag (address >= DEPTH seen).
module layer_dp_buffer #(
  parameter int DEPTH  = 144,
  parameter int DATA_W = 128,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic                 CK,
  input  logic                 rst,
  layer_dp_buffer_if.slave     bus,
  input  logic                 clr_start,
  output logic                 clr_busy,
  output logic                 col_flag,
  output logic [CNT_W-1:0]     col_cnt,
  output logic                 oor_flag
);

  // DEPTH may need one more bit than an address (e.g. DEPTH=4096, ADDR_W=12).
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   doa_q, doa_d, dob_q, dob_d;
  logic                doa_vld_q, doa_vld_d, dob_vld_q, dob_vld_d;
  logic                col_flag_q, col_flag_d, oor_q, oor_d;
  logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic a_ok, b_ok, a_rd, b_rd, a_wr, b_wr, same_addr, collide, b_wr_eff, idle;

  assign idle      = (state_q == IDLE);
  assign a_ok      = {1'b0, bus.A} < DEPTH_C;
  assign b_ok      = {1'b0, bus.B} < DEPTH_C;
  assign a_rd      = bus.CSA &  bus.WEAN;
  assign b_rd      = bus.CSB &  bus.WEBN;
  assign a_wr      = bus.CSA & ~bus.WEAN & a_ok;
  assign b_wr      = bus.CSB & ~bus.WEBN & b_ok;
  assign same_addr = (bus.A == bus.B);
  // Port A wins a write/write tie; port B's data is dropped.
  assign collide   = a_wr & b_wr & same_addr;
  assign b_wr_eff  = b_wr & ~collide;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    doa_d      = doa_q;
    dob_d      = dob_q;
    doa_vld_d  = 1'b0;
    dob_vld_d  = 1'b0;
    col_flag_d = col_flag_q;
    col_cnt_d  = col_cnt_q;
    oor_d      = oor_q;
    case (state_q)
      IDLE: begin
        // Write-first: a read sees the other port's same-cycle write.
        if (a_rd) begin
          doa_vld_d = 1'b1;
          if (!a_ok)                     doa_d = '0;
          else if (b_wr_eff && same_addr) doa_d = bus.DIB;
          else                           doa_d = mem_q[bus.A];
        end
        if (b_rd) begin
          dob_vld_d = 1'b1;
          if (!b_ok)                 dob_d = '0;
          else if (a_wr && same_addr) dob_d = bus.DIA;
          else                       dob_d = mem_q[bus.B];
        end
        if (collide) begin
          col_flag_d = 1'b1;
          if (col_cnt_q != '1) col_cnt_d = col_cnt_q + CNT_W'(1);
        end
        if ((bus.CSA && !a_ok) || (bus.CSB && !b_ok)) oor_d = 1'b1;
        // Starting a fill wipes the status flags.
        if (clr_start) begin
          state_d    = CLEAR;
          ptr_d      = '0;
          col_flag_d = 1'b0;
          col_cnt_d  = '0;
          oor_d      = 1'b0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_C) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      doa_q      <= '0;
      dob_q      <= '0;
      doa_vld_q  <= 1'b0;
      dob_vld_q  <= 1'b0;
      col_flag_q <= 1'b0;
      col_cnt_q  <= '0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      doa_q      <= doa_d;
      dob_q      <= dob_d;
      doa_vld_q  <= doa_vld_d;
      dob_vld_q  <= dob_vld_d;
      col_flag_q <= col_flag_d;
      col_cnt_q  <= col_cnt_d;
      oor_q      <= oor_d;
    end
  end

  // Array contents survive reset; reset only blocks the write of that cycle.
  always_ff @(posedge CK) begin
    if (!rst) begin
      if (!idle) begin
        mem_q[ptr_q] <= '0;
      end else begin
        if (b_wr_eff) mem_q[bus.B] <= bus.DIB;
        if (a_wr)     mem_q[bus.A] <= bus.DIA;
      end
    end
  end

  assign bus.DOA     = doa_q;
  assign bus.DOB     = dob_q;
  assign bus.DOA_vld = doa_vld_q;
  assign bus.DOB_vld = dob_vld_q;
  assign clr_busy    = !idle;
  assign col_flag    = col_flag_q;
  assign col_cnt     = col_cnt_q;
  assign oor_flag    = oor_q;

endmodule

// File: tb/tb_layer_dp_buffer.sv
// Randomised scoreboard bench for layer_dp_buffer against an array-based reference model.
// Latency: expects read data one cycle after each request. Backpressure: none modelled.
// Ports: drives the master side of layer_dp_buffer_if plus clr_start/rst.
module tb_layer_dp_buffer;
  localparam int DEPTH  = 144;
  localparam int DATA_W = 128;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [DATA_W-1:0] word_t;

  logic             CK = 1'b0;
  logic             rst;
  logic             clr_start;
  logic             clr_busy;
  logic             col_flag;
  logic [CNT_W-1:0] col_cnt;
  logic             oor_flag;

  always #5 CK = ~CK;

  layer_dp_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  layer_dp_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CK        (CK),
    .rst       (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .col_flag  (col_flag),
    .col_cnt   (col_cnt),
    .oor_flag  (oor_flag)
  );

  int    checks = 0;
  int    passed = 0;
  word_t qa[$];
  word_t qb[$];
  word_t model [DEPTH];
  bit    m_col, m_oor;
  int    m_cnt;
  word_t exp_last_a, exp_last_b;

  function automatic word_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void chk(string name, word_t act, word_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge CK) begin
    if (bus.DOA_vld) begin
      if (qa.size() == 0) begin
        checks++;
        $display("FAIL unexpected_DOA_vld: got vld=1, expected vld=0");
      end else chk("DOA", bus.DOA, qa.pop_front());
    end
    if (bus.DOB_vld) begin
      if (qb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_DOB_vld: got vld=1, expected vld=0");
      end else chk("DOB", bus.DOB, qb.pop_front());
    end
  end

  task automatic idle_bus();
    bus.CSA = 1'b0; bus.WEAN = 1'b1; bus.A = '0; bus.DIA = '0;
    bus.CSB = 1'b0; bus.WEBN = 1'b1; bus.B = '0; bus.DIB = '0;
  endtask

  // One cycle of requests on both ports; model computes expectations first.
  task automatic op(bit csa, bit wea, int a, word_t dia, bit csb, bit web, int b, word_t dib);
    bit    aw, bw;
    word_t e;
    aw = csa && !wea && (a < DEPTH);
    bw = csb && !web && (b < DEPTH);
    if (csa && wea) begin
      if (a >= DEPTH)         e = '0;
      else if (bw && b == a) e = dib;
      else                   e = model[a];
      qa.push_back(e);
      exp_last_a = e;
    end
    if (csb && web) begin
      if (b >= DEPTH)         e = '0;
      else if (aw && a == b) e = dia;
      else                   e = model[b];
      qb.push_back(e);
      exp_last_b = e;
    end
    if (aw && bw && a == b) begin
      m_col = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    if ((csa && a >= DEPTH) || (csb && b >= DEPTH)) m_oor = 1'b1;
    if (bw) model[b] = dib;
    if (aw) model[a] = dia;   // applied last so port A wins a tie
    bus.CSA = csa; bus.WEAN = wea; bus.A = ADDR_W'(a); bus.DIA = dia;
    bus.CSB = csb; bus.WEBN = web; bus.B = ADDR_W'(b); bus.DIB = dib;
    @(posedge CK); #1;
    idle_bus();
  endtask

  task automatic check_flags(string tag);
    chk({tag, "_col_flag"}, word_t'(col_flag), word_t'(m_col));
    chk({tag, "_col_cnt"},  word_t'(col_cnt),  word_t'(m_cnt));
    chk({tag, "_oor_flag"}, word_t'(oor_flag), word_t'(m_oor));
  endtask

  task automatic model_reset();
    m_col = 1'b0; m_cnt = 0; m_oor = 1'b0;
    exp_last_a = '0; exp_last_b = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH / 2; i++)
      op(1, 0, i, rnd_word(), 1, 0, i + DEPTH / 2, rnd_word());
  endtask

  task automatic read_all(string tag);
    for (int i = 0; i < DEPTH / 2; i++)
      op(1, 1, i, '0, 1, 1, i + DEPTH / 2, '0);
    @(posedge CK); #1;
    chk({tag, "_queues_drained"}, word_t'(qa.size() + qb.size()), '0);
  endtask

  initial begin
    int    busy_cnt, a, b;
    word_t w11, waa, w55;
    w11 = {16{8'h11}};
    waa = {16{8'hAA}};
    w55 = {16{8'h55}};
    rst = 1'b1; clr_start = 1'b0;
    idle_bus();
    model_reset();
    repeat (3) @(posedge CK);
    #1;
    chk("rst_DOA", bus.DOA, '0);
    chk("rst_DOB", bus.DOB, '0);
    chk("rst_vld", word_t'({bus.DOA_vld, bus.DOB_vld}), '0);
    chk("rst_busy", word_t'(clr_busy), '0);
    check_flags("rst");
    rst = 1'b0;

    // Basic write then read across ports.
    op(1, 0, 5, w11, 0, 1, 0, '0);
    op(0, 1, 0, '0, 1, 1, 5, '0);
    @(posedge CK); #1;
    chk("doa_stays_zero", bus.DOA, '0);

    // Write-first forwarding in both directions.
    op(1, 0, 7, waa, 1, 1, 7, '0);
    op(1, 1, 9, '0, 1, 0, 9, w55);

    // Writes must not disturb the read registers.
    op(1, 0, 20, rnd_word(), 1, 0, 21, rnd_word());
    chk("dob_hold", bus.DOB, exp_last_b);
    chk("doa_hold", bus.DOA, exp_last_a);

    // First collision: port A wins.
    op(1, 0, 3, word_t'(1), 1, 0, 3, word_t'(2));
    op(1, 1, 3, '0, 1, 1, 3, '0);
    check_flags("col1");

    // Fill everything so reads never hit uninitialised words, then random traffic.
    fill_random();
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, 15);
      b = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 255) : $urandom_range(0, 15);
      op($urandom_range(0, 1), $urandom_range(0, 1), a, rnd_word(),
         $urandom_range(0, 1), $urandom_range(0, 1), b, rnd_word());
    end
    check_flags("random");

    // Saturation of the collision counter.
    for (int i = 0; i < 300; i++) op(1, 0, i % DEPTH, rnd_word(), 1, 0, i % DEPTH, rnd_word());
    check_flags("sat");

    // Out-of-range requests.
    op(1, 1, 150, '0, 1, 1, 150, '0);
    op(1, 0, 200, rnd_word(), 0, 1, 0, '0);
    check_flags("oor");
    read_all("oor_unchanged");

    // Zero-fill: busy for exactly DEPTH cycles, port traffic ignored meanwhile.
    clr_start = 1'b1;
    model_reset();
    @(posedge CK); #1;
    clr_start = 1'b0;
    busy_cnt = 0;
    while (clr_busy && busy_cnt < DEPTH + 20) begin
      busy_cnt++;
      bus.CSA = 1'b1; bus.WEAN = $urandom_range(0, 1); bus.A = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.DIA = rnd_word();
      bus.CSB = 1'b1; bus.WEBN = 1'b1; bus.B = ADDR_W'($urandom_range(0, DEPTH - 1));
      @(posedge CK); #1;
    end
    idle_bus();
    chk("clr_busy_cycles", word_t'(busy_cnt), word_t'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    op(1, 1, DEPTH - 1, '0, 1, 1, 0, '0);
    check_flags("clr");
    read_all("clr_zero");

    // Reset in the middle of a fill.
    fill_random();
    clr_start = 1'b1;
    @(posedge CK); #1;
    clr_start = 1'b0;
    repeat (10) @(posedge CK);
    #1;
    chk("busy_before_rst", word_t'(clr_busy), word_t'(1));
    rst = 1'b1;
    @(posedge CK); #1;
    rst = 1'b0;
    chk("busy_after_rst", word_t'(clr_busy), '0);
    model_reset();
    for (int i = 0; i < 10; i++) model[i] = '0;
    check_flags("midrst");
    for (int i = 0; i < 20; i += 2) op(1, 1, i, '0, 1, 1, i + 1, '0);

    repeat (3) @(posedge CK);
    #1;
    chk("final_queues_drained", word_t'(qa.size() + qb.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
